// File: rtl/hwpe_ctrl_regfile_bist_ctrl_pkg.sv
// Shared definitions for the register-file march-test sequencer:
// state encoding, fail counter width and small state/counter helpers.
package hwpe_ctrl_bist_package;

  localparam int unsigned FailCntWidth = 8;

  typedef logic [3:0] bist_state_t;

  localparam bist_state_t IDLE  = 4'd0;
  localparam bist_state_t M0_W  = 4'd1;
  localparam bist_state_t M1_R  = 4'd2;
  localparam bist_state_t M1_W  = 4'd3;
  localparam bist_state_t M2_R  = 4'd4;
  localparam bist_state_t M2_W  = 4'd5;
  localparam bist_state_t M3_R  = 4'd6;
  localparam bist_state_t DRAIN = 4'd7;
  localparam bist_state_t DONE  = 4'd8;

  function automatic logic is_busy_state(input bist_state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

  function automatic logic is_access_state(input bist_state_t s);
    return is_busy_state(s) && (s != DRAIN);
  endfunction

  function automatic logic is_write_state(input bist_state_t s);
    return (s == M0_W) || (s == M1_W) || (s == M2_W);
  endfunction

  function automatic logic is_read_state(input bist_state_t s);
    return (s == M1_R) || (s == M2_R) || (s == M3_R);
  endfunction

  function automatic logic [FailCntWidth-1:0] sat_inc(input logic [FailCntWidth-1:0] v);
    return (v == {FailCntWidth{1'b1}}) ? v : v + {{(FailCntWidth-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/hwpe_ctrl_regfile_bist_ctrl_checker.sv
// Read-compare stage of the BIST sequencer: delays a read's expected value
// and address by one cycle to meet returning data, and keeps the fail record.
module hwpe_ctrl_bist_checker
  import hwpe_ctrl_bist_package::*;
#(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    flush_i,
  input  logic                    rd_issue_i,
  input  logic [DataWidth-1:0]    rd_exp_i,
  input  logic [AddrWidth-1:0]    rd_addr_i,
  input  logic [DataWidth-1:0]    rdata_i,
  output logic                    fail_o,
  output logic [AddrWidth-1:0]    fail_addr_o,
  output logic [FailCntWidth-1:0] fail_cnt_o
);

  logic                    valid_q, valid_d;
  logic [DataWidth-1:0]    exp_q, exp_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic                    fail_q, fail_d;
  logic [AddrWidth-1:0]    fail_addr_q, fail_addr_d;
  logic [FailCntWidth-1:0] fail_cnt_q, fail_cnt_d;
  logic                    mismatch_s;

  // Compare pipeline and fail bookkeeping next-state logic.
  always_comb begin
    mismatch_s = valid_q & ~flush_i & (rdata_i != exp_q);
    valid_d    = rd_issue_i & ~flush_i & ~clear_i;
    if (rd_issue_i) begin
      exp_d  = rd_exp_i;
      addr_d = rd_addr_i;
    end else begin
      exp_d  = '0;
      addr_d = '0;
    end
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_cnt_d  = fail_cnt_q;
    if (clear_i) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_cnt_d  = '0;
    end else if (mismatch_s) begin
      fail_d     = 1'b1;
      fail_cnt_d = sat_inc(fail_cnt_q);
      // Only the first mismatch of a run records its address.
      if (fail_cnt_q == {FailCntWidth{1'b0}}) begin
        fail_addr_d = addr_q;
      end else begin
        fail_addr_d = fail_addr_q;
      end
    end else begin
      fail_d = fail_q;
    end
  end

  // Checker state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      exp_q       <= '0;
      addr_q      <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      exp_q       <= exp_d;
      addr_q      <= addr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_cnt_o  = fail_cnt_q;

endmodule

// File: rtl/hwpe_ctrl_regfile_bist_ctrl.sv
// March-test sequencer driving the register-file wrapper BIST port:
// W(P) up, R(P)W(~P) up, R(~P)W(P) down, R(P) up, then a drain cycle.
module hwpe_ctrl_regfile_bist_ctrl
  import hwpe_ctrl_bist_package::*;
#(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumByte   = DataWidth / 8,
  parameter int unsigned NumWords  = 2 ** AddrWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [DataWidth-1:0]    pattern_i,
  output logic                    bist_o,
  output logic                    csn_o,
  output logic                    wen_o,
  output logic [AddrWidth-1:0]    addr_o,
  output logic [DataWidth-1:0]    wdata_o,
  output logic [NumByte-1:0]      be_o,
  input  logic [DataWidth-1:0]    rdata_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [AddrWidth-1:0]    fail_addr_o,
  output logic [FailCntWidth-1:0] fail_cnt_o
);

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);
  localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1);

  bist_state_t          state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic [DataWidth-1:0] pattern_q, pattern_d;
  logic                 bist_q, bist_d;
  logic                 csn_q, csn_d;
  logic                 wen_q, wen_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [NumByte-1:0]   be_q, be_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 start_acc_s, abort_acc_s, access_s;
  logic [DataWidth-1:0] rd_exp_s;

  // March sequencing: state and address counter next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pattern_d   = pattern_q;
    start_acc_s = 1'b0;
    abort_acc_s = 1'b0;
    if (is_busy_state(state_q) && abort_i) begin
      abort_acc_s = 1'b1;
      state_d     = IDLE;
      cnt_d       = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            start_acc_s = 1'b1;
            pattern_d   = pattern_i;
            state_d     = M0_W;
            cnt_d       = '0;
          end else begin
            state_d = state_q;
          end
        end
        M0_W: begin
          if (cnt_q == LastAddr) begin
            state_d = M1_R;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AddrOne;
          end
        end
        M1_R: state_d = M1_W;
        M1_W: begin
          if (cnt_q == LastAddr) begin
            state_d = M2_R;
            cnt_d   = LastAddr;
          end else begin
            state_d = M1_R;
            cnt_d   = cnt_q + AddrOne;
          end
        end
        M2_R: state_d = M2_W;
        M2_W: begin
          if (cnt_q == {AddrWidth{1'b0}}) begin
            state_d = M3_R;
            cnt_d   = '0;
          end else begin
            state_d = M2_R;
            cnt_d   = cnt_q - AddrOne;
          end
        end
        M3_R: begin
          if (cnt_q == LastAddr) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AddrOne;
          end
        end
        DRAIN: state_d = DONE;
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Port values for the upcoming state, so every output comes from a flop.
  always_comb begin
    access_s = is_access_state(state_d);
    csn_d    = ~access_s;
    wen_d    = ~is_write_state(state_d);
    busy_d   = is_busy_state(state_d);
    bist_d   = busy_d;
    done_d   = (state_d == DONE);
    if (access_s) begin
      addr_d = cnt_d;
      be_d   = {NumByte{1'b1}};
    end else begin
      addr_d = '0;
      be_d   = '0;
    end
    case (state_d)
      M0_W, M2_W: wdata_d = pattern_d;
      M1_W:       wdata_d = ~pattern_d;
      default:    wdata_d = '0;
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pattern_q <= '0;
      bist_q    <= 1'b0;
      csn_q     <= 1'b1;
      wen_q     <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      bist_q    <= bist_d;
      csn_q     <= csn_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_exp_s = (state_q == M2_R) ? ~pattern_q : pattern_q;

  hwpe_ctrl_bist_checker #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth)
  ) i_checker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (start_acc_s),
    .flush_i     (abort_acc_s),
    .rd_issue_i  (is_read_state(state_q)),
    .rd_exp_i    (rd_exp_s),
    .rd_addr_i   (cnt_q),
    .rdata_i     (rdata_i),
    .fail_o      (fail_o),
    .fail_addr_o (fail_addr_o),
    .fail_cnt_o  (fail_cnt_o)
  );

  assign bist_o  = bist_q;
  assign csn_o   = csn_q;
  assign wen_o   = wen_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign be_o    = be_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_bist_ctrl.sv
// Directed bench for the march-test sequencer with a one-cycle-latency
// register-file model that can inject a stuck-at bit or force zero reads.
module tb_hwpe_ctrl_regfile_bist_ctrl;

  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int NB      = 4;
  localparam int NW      = 32;
  localparam int RUN_LEN = 6 * NW + 1;

  logic          clk = 1'b0;
  logic          rst_i, start_i, abort_i;
  logic [DW-1:0] pattern_i;
  logic          bist_o, csn_o, wen_o, busy_o, done_o, fail_o;
  logic [AW-1:0] addr_o, fail_addr_o;
  logic [DW-1:0] wdata_o, rdata_i;
  logic [NB-1:0] be_o;
  logic [7:0]    fail_cnt_o;

  logic [DW-1:0] mem [NW];
  logic [DW-1:0] q_model = '0;
  logic          stuck_en = 1'b0;
  logic          rd_zero  = 1'b0;

  int            n_cmp = 0;
  int            n_err = 0;
  int            idx, seq_err, be_err;
  logic [DW-1:0] pat, last_w;

  always #5 clk = ~clk;

  hwpe_ctrl_regfile_bist_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .pattern_i   (pattern_i),
    .bist_o      (bist_o),
    .csn_o       (csn_o),
    .wen_o       (wen_o),
    .addr_o      (addr_o),
    .wdata_o     (wdata_o),
    .be_o        (be_o),
    .rdata_i     (rdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fail_o      (fail_o),
    .fail_addr_o (fail_addr_o),
    .fail_cnt_o  (fail_cnt_o)
  );

  // Register-file model: writes honour byte enables, reads return next cycle.
  always @(posedge clk) begin
    if (csn_o == 1'b0) begin
      if (wen_o == 1'b0) begin
        for (int b = 0; b < NB; b++) begin
          if (be_o[b]) mem[addr_o][8*b +: 8] <= wdata_o[8*b +: 8];
        end
      end else if (rd_zero) begin
        q_model <= '0;
      end else if (stuck_en && addr_o == 5'd12) begin
        q_model <= mem[addr_o] & 32'hFFFF_FFF7;
      end else begin
        q_model <= mem[addr_o];
      end
    end
  end

  assign rdata_i = q_model;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Compare the current port cycle against the march trace, then advance.
  task automatic step();
    logic          exp_acc, exp_wr;
    int            ea, j;
    logic [DW-1:0] ew;
    exp_acc = 1'b1; exp_wr = 1'b0; ea = 0; ew = '0; j = 0;
    if (idx < NW) begin
      exp_wr = 1'b1; ea = idx; ew = pat;
    end else if (idx < 3*NW) begin
      j = idx - NW; ea = j / 2; exp_wr = (j % 2) == 1; ew = ~pat;
    end else if (idx < 5*NW) begin
      j = idx - 3*NW; ea = NW - 1 - j / 2; exp_wr = (j % 2) == 1; ew = pat;
    end else if (idx < 6*NW) begin
      ea = idx - 5*NW;
    end else begin
      exp_acc = 1'b0;
    end
    if (exp_acc) begin
      if (csn_o !== 1'b0 || wen_o !== ~exp_wr || addr_o !== ea[4:0] ||
          (exp_wr && wdata_o !== ew)) seq_err++;
      if (be_o !== 4'hF) be_err++;
    end else if (csn_o !== 1'b1) begin
      seq_err++;
    end
    if (csn_o === 1'b0 && wen_o === 1'b0) last_w = wdata_o;
    idx++;
    @(negedge clk);
  endtask

  task automatic start_run(input logic [DW-1:0] p);
    pattern_i = p;
    start_i   = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    pat = p; idx = 0; seq_err = 0; be_err = 0; last_w = '0;
  endtask

  task automatic finish_run();
    while (busy_o === 1'b1 && idx < RUN_LEN + 20) step();
    check_eq("run_len", idx, RUN_LEN);
    check_eq("seq", seq_err, 0);
    check_eq("be", be_err, 0);
    check_eq("done", done_o, 1'b1);
  endtask

  task automatic check_reset_vals();
    check_eq("rst_ctl", {bist_o, busy_o, done_o, fail_o, csn_o, wen_o}, 6'b000011);
    check_eq("rst_port", {addr_o, wdata_o, be_o}, 0);
    check_eq("rst_fail", {fail_addr_o, fail_cnt_o}, 0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; pattern_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    check_reset_vals();

    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check_eq("idle_abort", {busy_o, csn_o, done_o}, 3'b010);

    start_run(32'hA5A5_A5A5);
    check_eq("busy_start", {busy_o, bist_o}, 2'b11);
    finish_run();
    check_eq("clean_fail", {fail_o, fail_cnt_o}, 0);
    check_eq("clean_lastw", last_w, 32'hA5A5_A5A5);

    stuck_en = 1'b1;
    start_run(32'hFFFF_FFFF);
    check_eq("done_clr", done_o, 1'b0);
    finish_run();
    check_eq("stuck_fail", fail_o, 1'b1);
    check_eq("stuck_addr", fail_addr_o, 12);
    check_eq("stuck_cnt", fail_cnt_o, 2);
    stuck_en = 1'b0;

    rd_zero = 1'b1;
    start_run(32'h0000_0001);
    check_eq("clr_on_start", {fail_o, fail_addr_o, fail_cnt_o}, 0);
    repeat (50) step();
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check_eq("abort_ctl", {busy_o, bist_o, done_o, csn_o}, 4'b0001);
    @(negedge clk);
    check_eq("abort_keep", {fail_o, fail_addr_o, fail_cnt_o}, {1'b1, 5'd0, 8'd9});

    start_run(32'h0000_0001);
    finish_run();
    check_eq("zero_cnt", fail_cnt_o, 96);
    check_eq("zero_addr", {fail_o, fail_addr_o}, {1'b1, 5'd0});
    rd_zero = 1'b0;

    start_run(32'hA5A5_A5A5);
    check_eq("restart_clr", {fail_o, fail_addr_o, fail_cnt_o}, 0);
    finish_run();
    check_eq("post_abort_clean", {fail_o, fail_cnt_o}, 0);

    start_run(32'h3C3C_5A5A);
    repeat (10) step();
    start_i = 1'b1; pattern_i = '0;
    step();
    start_i = 1'b0;
    finish_run();
    check_eq("busy_start_lastw", last_w, 32'h3C3C_5A5A);

    start_run(32'hA5A5_A5A5);
    repeat (20) step();
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    check_eq("abort_wins", {busy_o, done_o, csn_o}, 3'b001);

    stuck_en = 1'b1;
    start_run(32'hFFFF_FFFF);
    repeat (100) step();
    check_eq("pre_rst_fail", fail_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_reset_vals();
    stuck_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
